// File: rtl/serial_cmp_seq.sv
// Serial MSB-first magnitude comparator sequencer driving a shared one-bit
// combinational comparator cell; stops at the first differing bit position.
module serial_cmp_seq #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             lt_n,
    output logic             eq_n,
    output logic             gt_n,
    output logic             err,
    output logic [CW-1:0]    bit_cnt,
    output logic             cmp_in1,
    output logic             cmp_in2,
    input  logic             cmp_lt_n,
    input  logic             cmp_eq_n,
    input  logic             cmp_gt_n,
    output logic [1:0]       dbg_state
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;

    // Handshake: a request transfers on a rising edge where start=1 and
    // ready=1; start at any other time is dropped, never queued. done pulses
    // for one cycle when the result registers become valid.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= IW'(WIDTH - 1);
            lt_n    <= 1'b1;
            eq_n    <= 1'b1;
            gt_n    <= 1'b1;
            err     <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        idx     <= IW'(WIDTH - 1);
                        err     <= 1'b0;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    case ({cmp_lt_n, cmp_eq_n, cmp_gt_n})
                        3'b011: begin
                            {lt_n, eq_n, gt_n} <= 3'b011;
                            state              <= DONE;
                        end
                        3'b101: begin
                            // Equal bit: move on, unless this was the LSB.
                            if (idx != '0) begin
                                idx <= idx - IW'(1);
                            end else begin
                                {lt_n, eq_n, gt_n} <= 3'b101;
                                state              <= DONE;
                            end
                        end
                        3'b110: begin
                            {lt_n, eq_n, gt_n} <= 3'b110;
                            state              <= DONE;
                        end
                        default: begin
                            {lt_n, eq_n, gt_n} <= 3'b111;
                            err                <= 1'b1;
                            state              <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Cell inputs decode only registered state, so they are stable all cycle.
    assign cmp_in1 = busy ? a_q[idx] : 1'b0;
    assign cmp_in2 = busy ? b_q[idx] : 1'b0;

endmodule
